// File: rtl/random_pkg.sv
// Shared types, default tap masks and the LFSR step function for the
// whack-a-mole random source.
package random_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  // Fibonacci tap masks: bit i set feeds state[i] into the XOR feedback.
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [30:0] TAPS_W31 = 31'h40200240;
  localparam logic [31:0] TAPS_W32 = 32'h80200003;

  // One shift-left step with the parity of the tapped bits entering bit 0.
  // Operands are zero-extended to 64 bits so one function serves all widths.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int unsigned width);
    logic [63:0] mask;
    logic        fb;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    fb   = ^(state & taps & mask);
    return ((state << 1) | {63'd0, fb}) & mask;
  endfunction

endpackage

// File: rtl/random_lfsr_gen_lfsr_core.sv
// LFSR state register with seed load, single-step enable and a guard that
// keeps the all-zero lock-up state unreachable.
module lfsr_core
  import random_pkg::*;
#(
  parameter int unsigned       WIDTH   = 31,
  parameter logic [WIDTH-1:0]  TAPS    = TAPS_W31,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(10)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] RST_STATE = (RST_VAL == '0) ? WIDTH'(1) : RST_VAL;

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [63:0]      next_wide;

  always_comb begin
    next_wide = lfsr_next(64'(state_q), 64'(TAPS), WIDTH);
  end

  // NOTE: every combinational output gets its default first, so no path
  // through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (load_val_i == '0) ? WIDTH'(1) : load_val_i;
    end else if (step_i) begin
      state_d = next_wide[WIDTH-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/random_lfsr_gen.sv
// Seeded LFSR random source with a request/valid hole-index draw engine that
// never returns the same index twice in a row.
module random_lfsr_gen
  import random_pkg::*;
#(
  parameter int unsigned      WIDTH     = 31,
  parameter logic [WIDTH-1:0] TAPS      = TAPS_W31,
  parameter int unsigned      OUT_W     = 32,
  parameter int unsigned      SEED_INIT = 10,
  parameter int unsigned      NUM_HOLES = 9,
  parameter int unsigned      IDX_W     = 4,
  parameter int unsigned      MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gamestart,
  input  logic             refresh,
  input  logic             req,
  output logic [OUT_W-1:0] randout,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  output logic             busy
);

  localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);
  localparam logic [IDX_W:0]   NH_EXT   = (IDX_W + 1)'(NUM_HOLES);

  logic [WIDTH-1:0] seed_q, seed_d;
  logic             gs_q;
  draw_state_e      fsm_q, fsm_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             last_valid_q, last_valid_d;

  logic             rise;
  logic             draw_step;
  logic             lfsr_step;
  logic [WIDTH-1:0] state;
  logic [IDX_W-1:0] cand;
  logic             cand_in_range;
  logic             cand_fresh;
  logic [IDX_W:0]   idx_inc;
  logic [IDX_W-1:0] fallback_idx;

  assign rise = gamestart & ~gs_q;

  // Entropy comes from how long the player waits before starting.
  assign seed_d = gamestart ? seed_q : seed_q + WIDTH'(1);

  assign cand          = state[IDX_W-1:0];
  assign cand_in_range = {1'b0, cand} < NH_EXT;
  assign cand_fresh    = !last_valid_q || (cand != idx_q);
  assign idx_inc       = {1'b0, idx_q} + (IDX_W + 1)'(1);
  assign fallback_idx  = !last_valid_q ? '0 :
                         (idx_inc == NH_EXT) ? '0 : idx_inc[IDX_W-1:0];

  always_comb begin
    fsm_d        = fsm_q;
    tries_d      = tries_q;
    idx_d        = idx_q;
    idx_valid_d  = 1'b0;
    last_valid_d = last_valid_q;
    draw_step    = 1'b0;

    if (rise) begin
      fsm_d        = IDLE;
      last_valid_d = 1'b0;
    end else if (!gamestart) begin
      fsm_d = IDLE;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (req) begin
            fsm_d   = DRAW;
            tries_d = '0;
          end
        end
        DRAW: begin
          if (cand_in_range && cand_fresh) begin
            idx_d        = cand;
            idx_valid_d  = 1'b1;
            last_valid_d = 1'b1;
            fsm_d        = IDLE;
          end else if (tries_q == TRY_LAST) begin
            idx_d        = fallback_idx;
            idx_valid_d  = 1'b1;
            last_valid_d = 1'b1;
            fsm_d        = IDLE;
          end else begin
            draw_step = 1'b1;
            tries_d   = tries_q + TRY_W'(1);
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  // A refresh and a draw reject in the same cycle still advance only once.
  assign lfsr_step = gamestart & ~rise & (refresh | draw_step);

  always_ff @(posedge clk) begin
    if (!rst) begin
      seed_q       <= WIDTH'(SEED_INIT);
      gs_q         <= 1'b0;
      fsm_q        <= IDLE;
      tries_q      <= '0;
      idx_q        <= '0;
      idx_valid_q  <= 1'b0;
      last_valid_q <= 1'b0;
    end else begin
      seed_q       <= seed_d;
      gs_q         <= gamestart;
      fsm_q        <= fsm_d;
      tries_q      <= tries_d;
      idx_q        <= idx_d;
      idx_valid_q  <= idx_valid_d;
      last_valid_q <= last_valid_d;
    end
  end

  lfsr_core #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .RST_VAL(WIDTH'(SEED_INIT))
  ) u_lfsr_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (rise),
    .load_val_i(seed_q),
    .step_i    (lfsr_step),
    .state_o   (state)
  );

  generate
    if (OUT_W > WIDTH) begin : g_wide_out
      assign randout = {state, state[WIDTH-1 -: (OUT_W - WIDTH)]};
    end else begin : g_same_out
      assign randout = state;
    end
  endgenerate

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign busy      = (fsm_q == DRAW);

endmodule

// File: tb/tb_random_lfsr_gen.sv
// Directed bench: default instance plus a SEED_INIT=0 / MAX_TRIES=1 instance.
module tb_random_lfsr_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, gamestart, refresh, req;
  logic [31:0] randout;
  logic [3:0]  idx;
  logic        idx_valid, busy;

  logic        m_rst, m_gs, m_refresh, m_req;
  logic [31:0] m_randout;
  logic [3:0]  m_idx;
  logic        m_idx_valid, m_busy;

  int total = 0;
  int bad   = 0;

  random_lfsr_gen dut (
    .clk(clk), .rst(rst), .gamestart(gamestart), .refresh(refresh), .req(req),
    .randout(randout), .idx(idx), .idx_valid(idx_valid), .busy(busy)
  );

  random_lfsr_gen #(.SEED_INIT(0), .MAX_TRIES(1)) dut_m (
    .clk(clk), .rst(m_rst), .gamestart(m_gs), .refresh(m_refresh), .req(m_req),
    .randout(m_randout), .idx(m_idx), .idx_valid(m_idx_valid), .busy(m_busy)
  );

  task automatic step_clk(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_main(input string name, input logic [31:0] exp_rand,
                             input logic [3:0] exp_idx, input logic exp_valid,
                             input logic exp_busy);
    total++;
    if (randout !== exp_rand || idx !== exp_idx || idx_valid !== exp_valid || busy !== exp_busy) begin
      bad++;
      $display("FAIL %s: got randout=%h idx=%0d valid=%b busy=%b, want randout=%h idx=%0d valid=%b busy=%b",
               name, randout, idx, idx_valid, busy, exp_rand, exp_idx, exp_valid, exp_busy);
    end
  endtask

  task automatic expect_m(input string name, input logic [31:0] exp_rand,
                          input logic [3:0] exp_idx, input logic exp_valid,
                          input logic exp_busy);
    total++;
    if (m_randout !== exp_rand || m_idx !== exp_idx || m_idx_valid !== exp_valid || m_busy !== exp_busy) begin
      bad++;
      $display("FAIL %s: got randout=%h idx=%0d valid=%b busy=%b, want randout=%h idx=%0d valid=%b busy=%b",
               name, m_randout, m_idx, m_idx_valid, m_busy, exp_rand, exp_idx, exp_valid, exp_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; gamestart = 1'b0; refresh = 1'b0; req = 1'b0;
    step_clk(2);
    expect_main("reset", 32'h14, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_seed_start();
    rst = 1'b1;
    step_clk(5);
    gamestart = 1'b1;
    step_clk();
    expect_main("seed_load", 32'h1E, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_refresh();
    refresh = 1'b1;
    step_clk();
    refresh = 1'b0;
    expect_main("refresh_step", 32'h3C, 4'd0, 1'b0, 1'b0);
    step_clk();
    expect_main("refresh_hold", 32'h3C, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic test_draw();
    req = 1'b1;
    step_clk();
    req = 1'b0;
    expect_main("draw_e0", 32'h3C, 4'd0, 1'b0, 1'b1);
    step_clk();
    expect_main("draw_e1", 32'h78, 4'd0, 1'b0, 1'b1);
    step_clk();
    expect_main("draw_e2", 32'hF0, 4'd0, 1'b0, 1'b1);
    step_clk();
    expect_main("draw_accept", 32'hF0, 4'd8, 1'b1, 1'b0);
    step_clk();
    expect_main("draw_pulse_end", 32'hF0, 4'd8, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    req = 1'b1;
    step_clk();
    req = 1'b0;
    expect_main("b2b_e0", 32'hF0, 4'd8, 1'b0, 1'b1);
    step_clk();
    expect_main("b2b_repeat_reject", 32'h1E2, 4'd8, 1'b0, 1'b1);
    step_clk();
    expect_main("b2b_accept", 32'h1E2, 4'd1, 1'b1, 1'b0);
  endtask

  task automatic test_abort_gamestart();
    req = 1'b1;
    step_clk();
    req = 1'b0;
    expect_main("abort_e0", 32'h1E2, 4'd1, 1'b0, 1'b1);
    gamestart = 1'b0;
    step_clk();
    expect_main("abort_idle", 32'h1E2, 4'd1, 1'b0, 1'b0);
    req = 1'b1; refresh = 1'b1;
    step_clk();
    req = 1'b0; refresh = 1'b0;
    expect_main("abort_req_ignored", 32'h1E2, 4'd1, 1'b0, 1'b0);
    step_clk();
    expect_main("abort_frozen", 32'h1E2, 4'd1, 1'b0, 1'b0);
  endtask

  task automatic test_refresh_during_draw();
    rst = 1'b0;
    step_clk();
    rst = 1'b1; gamestart = 1'b1;
    step_clk();
    expect_main("restart_load", 32'h14, 4'd0, 1'b0, 1'b0);
    req = 1'b1;
    step_clk();
    expect_main("rd_e0", 32'h14, 4'd0, 1'b0, 1'b1);
    refresh = 1'b1;
    step_clk();
    req = 1'b0; refresh = 1'b0;
    expect_main("rd_single_step", 32'h28, 4'd0, 1'b0, 1'b1);
    step_clk();
    expect_main("rd_accept", 32'h28, 4'd4, 1'b1, 1'b0);
  endtask

  task automatic test_reset_during_draw();
    req = 1'b1;
    step_clk();
    req = 1'b0;
    expect_main("rst_draw_e0", 32'h28, 4'd4, 1'b0, 1'b1);
    rst = 1'b0;
    step_clk();
    expect_main("rst_draw_cleared", 32'h14, 4'd0, 1'b0, 1'b0);
    rst = 1'b1; gamestart = 1'b0;
  endtask

  task automatic test_zero_seed();
    expect_m("zero_reset_guard", 32'h2, 4'd0, 1'b0, 1'b0);
    m_rst = 1'b1; m_gs = 1'b1;
    step_clk();
    expect_m("zero_load_guard", 32'h2, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic m_draw();
    m_req = 1'b1;
    step_clk();
    m_req = 1'b0;
    step_clk();
  endtask

  task automatic test_fallback();
    m_gs = 1'b0;
    step_clk(8);
    m_gs = 1'b1;
    step_clk();
    expect_m("fb_seed8", 32'h10, 4'd0, 1'b0, 1'b0);
    m_draw();
    expect_m("fb_first_accept", 32'h10, 4'd8, 1'b1, 1'b0);
    step_clk();
    expect_m("fb_pulse_end", 32'h10, 4'd8, 1'b0, 1'b0);
    m_draw();
    expect_m("fb_wrap", 32'h10, 4'd0, 1'b1, 1'b0);
    step_clk();
    expect_m("fb_single_pulse", 32'h10, 4'd0, 1'b0, 1'b0);
    m_refresh = 1'b1;
    step_clk();
    m_refresh = 1'b0;
    m_draw();
    expect_m("fb_increment", 32'h20, 4'd1, 1'b1, 1'b0);
    m_gs = 1'b0;
    step_clk(4);
    m_gs = 1'b1;
    step_clk();
    expect_m("fb_seed12", 32'h18, 4'd1, 1'b0, 1'b0);
    m_draw();
    expect_m("fb_no_last", 32'h18, 4'd0, 1'b1, 1'b0);
  endtask

  initial begin
    m_rst = 1'b0; m_gs = 1'b0; m_refresh = 1'b0; m_req = 1'b0;
    test_reset();
    test_seed_start();
    test_refresh();
    test_draw();
    test_back_to_back();
    test_abort_gamestart();
    test_refresh_during_draw();
    test_reset_during_draw();
    test_zero_seed();
    test_fallback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
